// File: rtl/cpc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpc_mem_pkg
// Desc   : Shared widths, FSM encoding and pending-slot type for the CPC
//          memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package cpc_mem_pkg;

    localparam int CPU_AW  = 23;
    localparam int VRAM_AW = 15;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_VID  = 2'd1;
    localparam state_t c_ST_CPU  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [CPU_AW-1:0] addr;
        logic [7:0]        data;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/cpc_mem_req_slot.sv
`default_nettype none
// ============================================================================
// Module : cpc_mem_req_slot
// Desc   : Trigger detection plus a single pending-access slot with
//          set / overwrite / clear; set wins over a same-cycle clear.
// Rev    : 1.0 - initial release
// ============================================================================
module cpc_mem_req_slot
    import cpc_mem_pkg::*;
#(
    parameter bit STROBE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [CPU_AW-1:0] i_addr,
    input  logic [7:0]        i_data,
    input  logic              i_clr,
    output slot_t             o_slot,
    output logic              o_set,
    output logic              o_overrun
);

    logic              r_rd_d;
    logic              r_wr_d;
    logic [CPU_AW-1:0] r_addr_d;
    slot_t             r_slot;
    logic              w_set;

    // Level mode: rising rd/wr, or an address change during a held read.
    always_comb begin
        if (STROBE) begin
            w_set = i_rd;
        end else begin
            w_set = (i_rd & ~r_rd_d) | (i_wr & ~r_wr_d)
                  | (i_rd & r_rd_d & (i_addr != r_addr_d));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_d   <= 1'b0;
            r_wr_d   <= 1'b0;
            r_addr_d <= '0;
            r_slot   <= '0;
        end else begin
            r_rd_d   <= i_rd;
            r_wr_d   <= i_wr;
            r_addr_d <= i_addr;
            if (w_set) begin
                r_slot <= '{valid: 1'b1, we: i_wr, addr: i_addr, data: i_data};
            end else if (i_clr) begin
                r_slot.valid <= 1'b0;
            end
        end
    end

    assign o_slot    = r_slot;
    assign o_set     = w_set;
    assign o_overrun = w_set & r_slot.valid & ~i_clr;

endmodule
`default_nettype wire

// File: rtl/cpc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cpc_mem_arbiter
// Desc   : Serialises video fetches and Z80 accesses onto one 16-bit RAM
//          request/ack port; video has priority, requests are never aborted.
// Rev    : 1.0 - initial release
// ============================================================================
module cpc_mem_arbiter
    import cpc_mem_pkg::*;
#(
    parameter int          RAM_AW    = 22,
    parameter logic [31:0] VRAM_BASE = 32'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CPU_AW-1:0]  cpu_addr,
    input  logic [7:0]         cpu_wdata,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_busy,
    input  logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_req,
    output logic [15:0]        vram_rdata,
    output logic               vram_valid,
    output logic               vid_overrun,
    output logic               ram_req,
    output logic               ram_we,
    output logic [1:0]         ram_be,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [15:0]        ram_wdata,
    input  logic               ram_ack,
    input  logic [15:0]        ram_rdata
);

    localparam logic [RAM_AW-1:0] c_VRAM_BASE = RAM_AW'(VRAM_BASE);

    slot_t  w_cpu_slot;
    slot_t  w_vid_slot;
    logic   w_cpu_set;
    logic   w_cpu_ovr_unused;
    logic   w_vid_set_unused;
    logic   w_vid_ovr;
    logic   w_cpu_clr;
    logic   w_vid_clr;
    logic   w_unused_vid;
    state_t r_state;
    state_t w_state_nxt;
    logic   r_cpu_odd;

    assign w_cpu_clr = (r_state == c_ST_CPU) & ram_ack;
    assign w_vid_clr = (r_state == c_ST_VID) & ram_ack;

    cpc_mem_req_slot #(.STROBE(1'b0)) u_cpu_slot (
        .clk       (clk),
        .rst       (reset),
        .i_rd      (cpu_rd),
        .i_wr      (cpu_wr),
        .i_addr    (cpu_addr),
        .i_data    (cpu_wdata),
        .i_clr     (w_cpu_clr),
        .o_slot    (w_cpu_slot),
        .o_set     (w_cpu_set),
        .o_overrun (w_cpu_ovr_unused)
    );

    cpc_mem_req_slot #(.STROBE(1'b1)) u_vid_slot (
        .clk       (clk),
        .rst       (reset),
        .i_rd      (vram_req),
        .i_wr      (1'b0),
        .i_addr    (CPU_AW'(vram_addr)),
        .i_data    (8'd0),
        .i_clr     (w_vid_clr),
        .o_slot    (w_vid_slot),
        .o_set     (w_vid_set_unused),
        .o_overrun (w_vid_ovr)
    );

    assign w_unused_vid = ^{w_vid_slot.we, w_vid_slot.data,
                            w_vid_slot.addr[CPU_AW-1:VRAM_AW],
                            w_vid_set_unused, w_cpu_ovr_unused};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_vid_slot.valid) begin
                    w_state_nxt = c_ST_VID;
                end else if (w_cpu_slot.valid) begin
                    w_state_nxt = c_ST_CPU;
                end
            end
            c_ST_VID, c_ST_CPU: begin
                if (ram_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cpu_odd   <= 1'b0;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_be      <= 2'b00;
            ram_addr    <= '0;
            ram_wdata   <= 16'h0000;
            vram_valid  <= 1'b0;
            vid_overrun <= 1'b0;
            cpu_busy    <= 1'b0;
            cpu_rdata   <= 8'hFF;
            vram_rdata  <= 16'hFFFF;
        end else begin
            r_state     <= w_state_nxt;
            vram_valid  <= 1'b0;
            vid_overrun <= vid_overrun | w_vid_ovr;
            cpu_busy    <= w_cpu_set | (w_cpu_slot.valid & ~w_cpu_clr)
                         | (w_state_nxt == c_ST_CPU);
            case (r_state)
                c_ST_IDLE: begin
                    // Bus fields are loaded only here, so they hold for the whole request.
                    if (w_vid_slot.valid) begin
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_be    <= 2'b11;
                        ram_addr  <= c_VRAM_BASE + RAM_AW'(w_vid_slot.addr[VRAM_AW-1:0]);
                        ram_wdata <= 16'h0000;
                    end else if (w_cpu_slot.valid) begin
                        ram_req   <= 1'b1;
                        ram_we    <= w_cpu_slot.we;
                        ram_be    <= w_cpu_slot.we ? (w_cpu_slot.addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        ram_addr  <= RAM_AW'(w_cpu_slot.addr[CPU_AW-1:1]);
                        ram_wdata <= {w_cpu_slot.data, w_cpu_slot.data};
                        r_cpu_odd <= w_cpu_slot.addr[0];
                    end
                end
                c_ST_VID: begin
                    if (ram_ack) begin
                        ram_req    <= 1'b0;
                        vram_rdata <= ram_rdata;
                        vram_valid <= 1'b1;
                    end
                end
                c_ST_CPU: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (!ram_we) begin
                            cpu_rdata <= r_cpu_odd ? ram_rdata[15:8] : ram_rdata[7:0];
                        end
                    end
                end
                default: ram_req <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cpc_mem_arbiter
// Desc   : Self-checking bench for cpc_mem_arbiter: directed scenarios plus
//          random traffic against a byte-level memory reference.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cpc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic [14:0] vram_addr;
    logic        vram_req;
    logic [15:0] vram_rdata;
    logic        vram_valid;
    logic        vid_overrun;
    logic        ram_req;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [21:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack;
    logic [15:0] ram_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_cpu_rdata;
    logic [7:0]  ref_b [64];
    logic [15:0] ram_w [32];

    cpc_mem_arbiter #(.RAM_AW(22), .VRAM_BASE(32'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_rdata   (cpu_rdata),
        .cpu_busy    (cpu_busy),
        .vram_addr   (vram_addr),
        .vram_req    (vram_req),
        .vram_rdata  (vram_rdata),
        .vram_valid  (vram_valid),
        .vid_overrun (vid_overrun),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_be      (ram_be),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_ack     (ram_ack),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ram_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        vram_addr = '0; vram_req = 1'b0; ram_ack = 1'b0; ram_rdata = '0;
        step(); step();
        n_checks++;
        if ({ram_req, ram_we, ram_be, vram_valid, vid_overrun, cpu_busy} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {ram_req, ram_we, ram_be, vram_valid, vid_overrun, cpu_busy});
        end
        n_checks++;
        if (ram_addr !== 22'd0 || ram_wdata !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_bus: got addr %h wdata %h expected 0 0", ram_addr, ram_wdata);
        end
        n_checks++;
        if (cpu_rdata !== 8'hFF || vram_rdata !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h expected ff ffff", cpu_rdata, vram_rdata);
        end
        reset = 1'b0;
        step(); step();
        n_checks++;
        if (ram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got ram_req %b expected 0", ram_req);
        end
        exp_cpu_rdata = 8'hFF;
    endtask

    task automatic test_video_read();
        vram_addr = 15'h1234; vram_req = 1'b1;
        step();
        vram_req = 1'b0;
        n_checks++;
        if (ram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL vid_capture: got ram_req %b expected 0", ram_req);
        end
        step();
        n_checks++;
        if (ram_req !== 1'b1 || ram_addr !== 22'h1234 || ram_we !== 1'b0 || ram_be !== 2'b11) begin
            n_errors++;
            $display("FAIL vid_issue: got req %b addr %h we %b be %b expected 1 001234 0 11",
                     ram_req, ram_addr, ram_we, ram_be);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ram_req !== 1'b1 || ram_addr !== 22'h1234) begin
                n_errors++;
                $display("FAIL vid_hold: got req %b addr %h expected 1 001234", ram_req, ram_addr);
            end
        end
        ram_ack = 1'b1; ram_rdata = 16'hBEEF;
        step();
        ram_ack = 1'b0;
        n_checks++;
        if (vram_valid !== 1'b1 || vram_rdata !== 16'hBEEF || ram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL vid_done: got valid %b data %h req %b expected 1 beef 0",
                     vram_valid, vram_rdata, ram_req);
        end
        step();
        n_checks++;
        if (vram_valid !== 1'b0 || vram_rdata !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL vid_pulse: got valid %b data %h expected 0 beef", vram_valid, vram_rdata);
        end
    endtask

    task automatic test_cpu_odd_read();
        bit ok;
        cpu_addr = 23'h04001; cpu_rd = 1'b1;
        step();
        n_checks++;
        if (cpu_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_busy: got %b expected 1", cpu_busy);
        end
        wait_req(ok);
        n_checks++;
        if (!ok || ram_addr !== 22'h02000 || ram_we !== 1'b0 || ram_be !== 2'b11) begin
            n_errors++;
            $display("FAIL rd_issue: got ok %b addr %h we %b be %b expected 1 002000 0 11",
                     ok, ram_addr, ram_we, ram_be);
        end
        ram_ack = 1'b1; ram_rdata = 16'hA55A;
        step();
        ram_ack = 1'b0;
        exp_cpu_rdata = 8'hA5;
        n_checks++;
        if (cpu_rdata !== exp_cpu_rdata || cpu_busy !== 1'b0 || ram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_done: got data %h busy %b req %b expected a5 0 0",
                     cpu_rdata, cpu_busy, ram_req);
        end
        cpu_rd = 1'b0;
        step();
    endtask

    task automatic test_cpu_even_write();
        bit ok;
        cpu_addr = 23'h00010; cpu_wdata = 8'h3C; cpu_wr = 1'b1;
        step();
        wait_req(ok);
        n_checks++;
        if (!ok || ram_we !== 1'b1 || ram_be !== 2'b01 || ram_wdata !== 16'h3C3C || ram_addr !== 22'h8) begin
            n_errors++;
            $display("FAIL wr_issue: got ok %b we %b be %b wdata %h addr %h expected 1 1 01 3c3c 000008",
                     ok, ram_we, ram_be, ram_wdata, ram_addr);
        end
        ram_ack = 1'b1; ram_rdata = 16'h1357;
        step();
        ram_ack = 1'b0;
        n_checks++;
        if (cpu_rdata !== exp_cpu_rdata || cpu_busy !== 1'b0 || ram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_done: got data %h busy %b req %b expected %h 0 0",
                     cpu_rdata, cpu_busy, ram_req, exp_cpu_rdata);
        end
        cpu_wr = 1'b0;
        step();
    endtask

    task automatic test_priority();
        bit ok;
        logic [15:0] d1, d2;
        d1 = 16'($urandom); d2 = 16'($urandom);
        cpu_addr = 23'h00123; cpu_rd = 1'b1; vram_addr = 15'h0055; vram_req = 1'b1;
        step();
        vram_req = 1'b0;
        wait_req(ok);
        n_checks++;
        if (!ok || ram_addr !== 22'h55 || ram_we !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_first: got ok %b addr %h we %b expected 1 000055 0", ok, ram_addr, ram_we);
        end
        ram_ack = 1'b1; ram_rdata = d1;
        step();
        ram_ack = 1'b0;
        n_checks++;
        if (ram_req !== 1'b0 || vram_valid !== 1'b1 || vram_rdata !== d1) begin
            n_errors++;
            $display("FAIL prio_gap: got req %b valid %b data %h expected 0 1 %h",
                     ram_req, vram_valid, vram_rdata, d1);
        end
        step();
        n_checks++;
        if (ram_req !== 1'b1 || ram_addr !== 22'h91) begin
            n_errors++;
            $display("FAIL prio_second: got req %b addr %h expected 1 000091", ram_req, ram_addr);
        end
        ram_ack = 1'b1; ram_rdata = d2;
        step();
        ram_ack = 1'b0;
        exp_cpu_rdata = d2[15:8];
        n_checks++;
        if (cpu_rdata !== exp_cpu_rdata) begin
            n_errors++;
            $display("FAIL prio_cpu_data: got %h expected %h", cpu_rdata, exp_cpu_rdata);
        end
        cpu_rd = 1'b0;
        step();
    endtask

    task automatic test_reread();
        bit ok;
        logic [15:0] d;
        d = 16'($urandom);
        cpu_addr = 23'h00007; cpu_rd = 1'b1;
        step();
        wait_req(ok);
        ram_ack = 1'b1; ram_rdata = d;
        step();
        ram_ack = 1'b0;
        exp_cpu_rdata = d[15:8];
        n_checks++;
        if (!ok || cpu_rdata !== exp_cpu_rdata) begin
            n_errors++;
            $display("FAIL reread_first: got ok %b data %h expected 1 %h", ok, cpu_rdata, exp_cpu_rdata);
        end
        cpu_addr = 23'h00008;
        step();
        wait_req(ok);
        n_checks++;
        if (!ok || ram_addr !== 22'h4) begin
            n_errors++;
            $display("FAIL reread_issue: got ok %b addr %h expected 1 000004", ok, ram_addr);
        end
        d = 16'($urandom);
        ram_ack = 1'b1; ram_rdata = d;
        step();
        ram_ack = 1'b0;
        exp_cpu_rdata = d[7:0];
        n_checks++;
        if (cpu_rdata !== exp_cpu_rdata) begin
            n_errors++;
            $display("FAIL reread_data: got %h expected %h", cpu_rdata, exp_cpu_rdata);
        end
        cpu_rd = 1'b0;
        step();
    endtask

    task automatic test_overrun();
        bit ok;
        bit extra;
        n_checks++;
        if (vid_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_clear: got %b expected 0", vid_overrun);
        end
        cpu_addr = 23'h00200; cpu_rd = 1'b1;
        step();
        wait_req(ok);
        vram_addr = 15'h0AAA; vram_req = 1'b1;
        step();
        vram_req = 1'b0;
        step();
        n_checks++;
        if (vid_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_single: got %b expected 0", vid_overrun);
        end
        vram_addr = 15'h0BBB; vram_req = 1'b1;
        step();
        vram_req = 1'b0;
        step(); step();
        n_checks++;
        if (vid_overrun !== 1'b1 || ram_req !== 1'b1 || ram_addr !== 22'h100) begin
            n_errors++;
            $display("FAIL ovr_set: got ovr %b req %b addr %h expected 1 1 000100",
                     vid_overrun, ram_req, ram_addr);
        end
        ram_ack = 1'b1; ram_rdata = 16'h7E81;
        step();
        ram_ack = 1'b0; cpu_rd = 1'b0;
        exp_cpu_rdata = 8'h81;
        wait_req(ok);
        n_checks++;
        if (!ok || ram_addr !== 22'h0BBB) begin
            n_errors++;
            $display("FAIL ovr_fetch: got ok %b addr %h expected 1 000bbb", ok, ram_addr);
        end
        ram_ack = 1'b1; ram_rdata = 16'hC0DE;
        step();
        ram_ack = 1'b0;
        n_checks++;
        if (vram_rdata !== 16'hC0DE || vram_valid !== 1'b1 || cpu_rdata !== exp_cpu_rdata) begin
            n_errors++;
            $display("FAIL ovr_data: got vdata %h valid %b cdata %h expected c0de 1 %h",
                     vram_rdata, vram_valid, cpu_rdata, exp_cpu_rdata);
        end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ram_req !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra || vid_overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_sticky: got extra_req %b ovr %b expected 0 1", extra, vid_overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        vram_addr = 15'h0321; vram_req = 1'b1;
        step();
        vram_req = 1'b0;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL rstmid_issue: got no ram_req expected 1");
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({ram_req, ram_we, ram_be, vram_valid, vid_overrun, cpu_busy} !== 7'd0 ||
            ram_addr !== 22'd0 || cpu_rdata !== 8'hFF || vram_rdata !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL rstmid_vals: got ctl %b addr %h cdata %h vdata %h expected 0 0 ff ffff",
                     {ram_req, ram_we, ram_be, vram_valid, vid_overrun, cpu_busy},
                     ram_addr, cpu_rdata, vram_rdata);
        end
        step();
        ram_ack = 1'b1; ram_rdata = 16'h5A5A;
        step();
        ram_ack = 1'b0;
        step();
        n_checks++;
        if (vram_valid !== 1'b0 || vram_rdata !== 16'hFFFF || ram_req !== 1'b0 || cpu_rdata !== 8'hFF) begin
            n_errors++;
            $display("FAIL rstmid_stray: got valid %b vdata %h req %b cdata %h expected 0 ffff 0 ff",
                     vram_valid, vram_rdata, ram_req, cpu_rdata);
        end
        exp_cpu_rdata = 8'hFF;
    endtask

    task automatic test_random();
        int          kind;
        int          lat;
        bit          ok;
        logic [5:0]  b;
        logic [4:0]  w;
        logic [7:0]  d;
        logic [15:0] rsp;
        logic [15:0] exp16;
        logic [21:0] exp_a;
        logic        exp_we;
        logic [1:0]  exp_be;
        for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) ram_w[i] = {ref_b[2*i+1], ref_b[2*i]};
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, 3));
            b = 6'($urandom); w = 5'($urandom); d = 8'($urandom);
            if (kind == 0) begin
                vram_addr = {10'd0, w}; vram_req = 1'b1;
                exp_a = {17'd0, w}; exp_we = 1'b0; exp_be = 2'b11;
            end else if (kind == 1) begin
                cpu_addr = {17'd0, b}; cpu_rd = 1'b1;
                exp_a = {17'd0, b[5:1]}; exp_we = 1'b0; exp_be = 2'b11;
            end else begin
                cpu_addr = {17'd0, b}; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = 1'($urandom);
                exp_a = {17'd0, b[5:1]}; exp_we = 1'b1; exp_be = b[0] ? 2'b10 : 2'b01;
            end
            step();
            vram_req = 1'b0;
            wait_req(ok);
            n_checks++;
            if (!ok || ram_addr !== exp_a || ram_we !== exp_we || ram_be !== exp_be ||
                (exp_we && ram_wdata !== {d, d})) begin
                n_errors++;
                $display("FAIL rnd_issue[%0d]: got ok %b addr %h we %b be %b wdata %h expected 1 %h %b %b %h",
                         t, ok, ram_addr, ram_we, ram_be, ram_wdata, exp_a, exp_we, exp_be, {d, d});
            end
            repeat (lat) step();
            n_checks++;
            if (ram_req !== 1'b1 || ram_addr !== exp_a) begin
                n_errors++;
                $display("FAIL rnd_hold[%0d]: got req %b addr %h expected 1 %h", t, ram_req, ram_addr, exp_a);
            end
            rsp = 16'hDEAD;
            if (ram_addr < 22'd32) begin
                rsp = ram_w[ram_addr[4:0]];
                if (ram_we === 1'b1) begin
                    if (ram_be[0]) ram_w[ram_addr[4:0]][7:0]  = ram_wdata[7:0];
                    if (ram_be[1]) ram_w[ram_addr[4:0]][15:8] = ram_wdata[15:8];
                end
            end
            ram_ack = 1'b1; ram_rdata = rsp;
            step();
            ram_ack = 1'b0; ram_rdata = 16'($urandom);
            if (kind == 0) begin
                exp16 = {ref_b[{w, 1'b1}], ref_b[{w, 1'b0}]};
                n_checks++;
                if (vram_valid !== 1'b1 || vram_rdata !== exp16) begin
                    n_errors++;
                    $display("FAIL rnd_vid[%0d]: got valid %b data %h expected 1 %h",
                             t, vram_valid, vram_rdata, exp16);
                end
            end else begin
                if (kind == 1) exp_cpu_rdata = ref_b[b];
                else ref_b[b] = d;
                n_checks++;
                if (cpu_rdata !== exp_cpu_rdata || cpu_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rnd_cpu[%0d]: got data %h busy %b expected %h 0",
                             t, cpu_rdata, cpu_busy, exp_cpu_rdata);
                end
            end
            cpu_rd = 1'b0; cpu_wr = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_video_read();
        test_cpu_odd_read();
        test_cpu_even_write();
        test_priority();
        test_reread();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cpc_mem_arbiter.md
# cpc_mem_arbiter

Arbiter between the CPC motherboard and a single 16-bit word-wide RAM controller port. Serialises gate-array video fetches and Z80 memory reads and writes onto one request/acknowledge channel. Video always has priority. Returns CPU bytes and video words on registered outputs. Sits directly upstream of the motherboard's `mem_din`/`vram_din` inputs and consumes its `mem_addr`/`mem_rd`/`mem_wr`/`vram_addr` outputs.

## Interface

Clock is `clk`; reset is `reset`, synchronous, active-high.

Parameters:
- `RAM_AW`, default 22: RAM word-address width. Covers the 23-bit CPU byte address.
- `VRAM_BASE`, default 0: word-address base of the video bank, right-aligned; `vram_addr` is added onto it.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: sync active-high reset.
- `cpu_addr` in 23: CPU byte address (`mem_addr`).
- `cpu_wdata` in 8: CPU write byte.
- `cpu_rd` in 1: level; CPU memory read active.
- `cpu_wr` in 1: level; CPU memory write active.
- `cpu_rdata` out 8: last CPU read byte, held.
- `cpu_busy` out 1: CPU access pending or in flight.
- `vram_addr` in 15: video word address.
- `vram_req` in 1: one-cycle fetch strobe.
- `vram_rdata` out 16: last video word, held.
- `vram_valid` out 1: one-cycle pulse when `vram_rdata` updates.
- `vid_overrun` out 1: sticky; a `vram_req` arrived while a video fetch was still pending. Cleared only by reset.
- `ram_req` out 1: request, held until ack.
- `ram_we` out 1: write qualifier.
- `ram_be` out 2: byte enables; bit0 = low byte (even address).
- `ram_addr` out RAM_AW: word address.
- `ram_wdata` out 16: write data.
- `ram_ack` in 1: one-cycle acknowledge; `ram_rdata` is valid in the same cycle.
- `ram_rdata` in 16: read data.

## Operation

- **CPU trigger.** A new CPU access is triggered by any of:
  - rising edge of `cpu_rd`;
  - rising edge of `cpu_wr`;
  - change of `cpu_addr` while `cpu_rd` stays high (re-read).
- **CPU pending slot.** The trigger captures address, write flag and data into the CPU pending slot.
  - If `cpu_rd` and `cpu_wr` are both high, the access is a write.
  - A new trigger while the slot is already pending overwrites it; the latest access wins.
- **Video pending slot.** `vram_req` captures `vram_addr` into the video pending slot.
  - If the slot is already pending: overwrite it and set `vid_overrun`.
- **FSM states.**
  - IDLE:
    - video pending → VID;
    - else CPU pending → CPU.
  - VID:
    - `ram_addr` = `VRAM_BASE` + `vram_addr`;
    - `ram_we` = 0, `ram_be` = 11.
    - On `ram_ack`: latch `ram_rdata` into `vram_rdata`, pulse `vram_valid`, clear the video slot, go to IDLE.
  - CPU:
    - `ram_addr` = `cpu_addr[22:1]`, zero-extended to RAM_AW.
    - Read: `be` = 11; on ack, `cpu_rdata` = high byte if `cpu_addr[0]`, else low byte.
    - Write: `ram_wdata` = {`cpu_wdata`, `cpu_wdata`}, `be` = 10 if `addr[0]`, else 01, `we` = 1. `cpu_rdata` is unchanged.
    - On ack: clear the CPU slot, go to IDLE.
- **Request hold.** An in-flight request is never aborted or re-prioritised. A `vram_req` arriving during CPU state waits.
- **Stray acks.** `ram_ack` in IDLE is ignored.
- **Busy.** `cpu_busy` = CPU slot pending OR state == CPU.
- **Reset.**
  - Takes effect on the next edge: state IDLE, slots cleared, `vid_overrun` 0.
  - Any late `ram_ack` after reset is ignored.
- **Output reset values:**
  - all of these 0: `ram_req`, `ram_we`, `ram_be`, `ram_addr`, `ram_wdata`, `vram_valid`, `vid_overrun`, `cpu_busy`;
  - `cpu_rdata` = FF;
  - `vram_rdata` = FFFF.

## Timing

- All outputs are registered.
- **Capture.** Trigger or `vram_req` seen at edge N → slot set at N+1.
- **Issue.** IDLE with a slot pending at N → `ram_req`, address and data valid at N+1.
- **Completion.** `ram_ack` at cycle K:
  - `ram_req` low at K+1;
  - data outputs and `vram_valid` at K+1;
  - state IDLE at K+1.
- **Back-to-back.** The next request is issued at K+2 at the earliest, so `ram_req` is low for at least one cycle between requests.
- **Hold stability.** `ram_addr`, `ram_we`, `ram_be` and `ram_wdata` are stable for the whole time `ram_req` is high.
- **Simultaneous capture.** Video and CPU captured in the same cycle: video is issued first; CPU follows at ack+2.

## Structure

- **Package `cpc_mem_pkg`:**
  - state enum (IDLE, VID, CPU);
  - constants `CPU_AW = 23`, `VRAM_AW = 15`;
  - a pending-slot struct {valid, we, addr, data}.
- **One sub-module, `cpc_mem_req_slot`:**
  - edge detect plus pending-slot register with set/overwrite/clear;
  - instantiated twice (CPU, video).
  - The video instance exports its overrun condition.

## Test plan

- **Video read.** `vram_req` with `vram_addr` = 0x1234, `VRAM_BASE` = 0, ack 3 cycles after `ram_req` returning 0xBEEF → `ram_addr` = 0x1234, `ram_we` = 0; `vram_rdata` = 0xBEEF with a one-cycle `vram_valid` at ack+1.
- **CPU odd-byte read.** `cpu_rd` rise with `cpu_addr` = 0x04001, ack data 0xA55A → `ram_addr` = 0x02000; `cpu_rdata` = 0xA5; `cpu_busy` drops at ack+1.
- **CPU even-byte write.** `cpu_wr` rise with `cpu_addr` = 0x00010, data 0x3C → `ram_we` = 1, `be` = 01, `ram_wdata` = 0x3C3C, `ram_addr` = 0x8; `cpu_rdata` unchanged.
- **Priority.** `cpu_rd` and `vram_req` in the same cycle → video request issued first; CPU request at video ack+2; one `ram_req` gap cycle between them.
- **Overrun.** Two `vram_req` pulses with the RAM stalled (no ack) → `vid_overrun` = 1 and stays 1; only the second address is fetched.
- **Reset mid-request.** Reset while `ram_req` is high, then `ram_ack` 2 cycles later → all outputs at reset values; the ack produces no `vram_valid` and no data change.
